// File: rtl/fact_dp_if.sv
// Operand/strobe/result bundle between the factorial control unit and its datapath.
// The control unit (or a bench standing in for it) drives through the master modport.
interface fact_dp_if #(
    parameter int NW    = 4,
    parameter int WIDTH = 32
);
    logic [NW-1:0]    n;
    logic             cld;
    logic             cen;
    logic             s1;
    logic             ren;
    logic             ben;
    logic             greater;
    logic [WIDTH-1:0] out;
    logic             err;

    modport master (
        output n, cld, cen, s1, ren, ben,
        input  greater, out, err
    );

    modport slave (
        input  n, cld, cen, s1, ren, ben,
        output greater, out, err
    );
endinterface

// File: rtl/fact_dp.sv
// Iterative factorial datapath: saturating down-counter, product register with
// single-cycle multiplier, sticky overflow flag and a registered result buffer.
module fact_dp #(
    parameter int NW    = 4,
    parameter int WIDTH = 32
) (
    input logic      Clk,
    input logic      Rst,
    fact_dp_if.slave bus
);
    localparam int PW = WIDTH + NW;

    logic [NW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] prod_reg, prod_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             err_reg, err_next;
    logic [PW-1:0]    full_prod;

    // Full-width product so overflow can be seen in the bits above WIDTH.
    assign full_prod = PW'(prod_reg) * PW'(count_reg);

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_next = count_reg;
        if (bus.cld) begin
            count_next = bus.n;
        end else if (bus.cen && (count_reg != '0)) begin
            count_next = count_reg - NW'(1);
        end
    end

    always_comb begin
        prod_next = prod_reg;
        ovf_next  = ovf_reg;
        if (bus.ren) begin
            if (bus.s1) begin
                prod_next = full_prod[WIDTH-1:0];
                ovf_next  = ovf_reg | (|full_prod[PW-1:WIDTH]);
            end else begin
                prod_next = WIDTH'(1);
                ovf_next  = 1'b0;
            end
        end
    end

    // The buffer captures the pre-edge product even when ren fires alongside.
    always_comb begin
        out_next = out_reg;
        err_next = err_reg;
        if (bus.ben) begin
            out_next = prod_reg;
            err_next = ovf_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_reg <= '0;
            prod_reg  <= '0;
            ovf_reg   <= 1'b0;
            out_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            prod_reg  <= prod_next;
            ovf_reg   <= ovf_next;
            out_reg   <= out_next;
            err_reg   <= err_next;
        end
    end

    assign bus.greater = (count_reg > NW'(1));
    assign bus.out     = out_reg;
    assign bus.err     = err_reg;
endmodule

// File: doc/fact_dp.md
Name: fact_dp

Overview:
- Datapath half of the iterative factorial engine; computes n! under direction of the factorial control unit.
- Consumes the unit's per-state control strobes (cld, cen, s1, ren, ben) and returns the loop-condition flag `greater`.
- Holds a down-counter, a product register with multiplier, a sticky overflow flag and a registered result buffer.
- Sits between the external operand/result interface and the control unit; the control unit alone owns go/done sequencing.

Parameters:
- NW, 4: width of operand n and of the down-counter.
- WIDTH, 32: width of product register, result buffer and `out`.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- n  in  NW  operand; sampled only on a cld cycle.
- cld  in  1  counter load strobe.
- cen  in  1  counter decrement enable.
- s1  in  1  product-mux select: 0 = constant 1, 1 = product*count.
- ren  in  1  product register load enable.
- ben  in  1  result buffer load enable.
- greater  out  1  combinational: count > 1.
- out  out  WIDTH  registered result.
- err  out  1  registered overflow flag accompanying `out`.

Behaviour:
- Reset: Rst high at a Clk edge sets count=0, prod=0, ovf=0, out=0, err=0. `greater` is therefore 0 the cycle after reset.
  - Reset mid-computation discards all progress; no partial result reaches `out`.
  - Rst overrides every strobe in the same cycle.
- Counter, per edge, in priority order:
  - cld=1: count<=n. cen is ignored, so the control unit's Load code (cld=1, cen=1) loads rather than decrements.
  - else cen=1 and count!=0: count<=count-1.
  - else cen=1 and count==0: hold at 0 (saturate, no wrap to 2^NW-1).
  - else hold.
- greater = (count > 1), purely combinational from the count register, zero-latency. Valid in the control unit's Wait state, which follows Load/Dec by one edge.
- Product register, when ren=1:
  - s1=0: prod<=1 and ovf<=0; this is the init path.
  - s1=1: full product P = prod*count (WIDTH+NW bits); prod<=P[WIDTH-1:0]; ovf<=ovf | (P[WIDTH+NW-1:WIDTH]!=0). ovf is sticky.
  - Multiply uses pre-edge count. In Dec (cen=1, s1=1, ren=1) the edge yields prod*count_old and count_old-1 together.
  - ren=0: prod and ovf hold.
- Result buffer, when ben=1: out<=prod, err<=ovf.
  - ben=1 together with ren=1 captures the pre-edge prod and ovf.
  - ben=0: out and err hold their last value indefinitely.
- Operand edge cases:
  - n=0 or n=1: greater=0 right after Load; result is 1 with err=0.
  - n is don't-care except on cld cycles.
- Strobe coverage: any combination of strobes is legal and handled per the rules above. No illegal-combination detection.
- Latency: for n>=2, Load + (n-1) x (Wait + Dec) + Wait + Done. `out` is valid the edge after Done, i.e. 2n+1 cycles after Load for n>=2 and 3 cycles for n<=1.
- Arithmetic is unsigned throughout. Multiplier is single-cycle combinational; no internal pipelining.

Test Plan:
- Reset, then n=5 driven with the control sequence Load, {Wait, Dec}x4, Wait, Done -> greater drops to 0 after 4th Dec; out=120, err=0.
- n=0 and n=1 with Load, Wait, Done -> greater=0 in Wait; out=1, err=0 both cases.
- n=12 full sequence -> out=479001600, err=0. Then n=13 -> out=1932053504 (13! mod 2^32), err=1. Next Load (s1=0, ren=1) clears ovf.
- cld=1 with cen=1, n=7, count previously 3 -> count=7 next cycle, greater=1. Then cen=1 with count=0 for 3 cycles -> count stays 0.
- ben=1 and ren=1 in same cycle, prod=24 before edge, next product 120 -> out=24, prod=120.
- Rst asserted mid-loop with n=9 after 3 Decs, out=120 held from earlier run -> next edge count=0, prod=0, out=0, err=0, greater=0.
